// File: rtl/fifo_uart_tx_if.sv
// Read-port / serial-line bundle between the byte FIFO, the UART drainer and the pin.
interface fifo_uart_tx_if;
    logic       fifo_empty;
    logic [7:0] fifo_data;
    logic       fifo_rd_en;
    logic       tx;
    logic       busy;
    logic       tx_done;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd_en,
        output tx,
        output busy,
        output tx_done
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd_en,
        input  tx,
        input  busy,
        input  tx_done
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// Drains the byte FIFO one entry at a time and shifts each byte out as an 8N1 UART frame.
module fifo_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104
) (
    input  logic           clk,
    input  logic           rst,
    fifo_uart_tx_if.master bus
);

    localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;
    logic          rd_en_q, rd_en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    // State, counters and every output are flops; outputs are derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            rd_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            rd_en_q <= rd_en_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (!bus.fifo_empty) state_d = FETCH;
            end
            FETCH: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d = bus.fifo_data;
                cyc_d   = '0;
                state_d = START;
            end
            START: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = DATA;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            DATA: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) state_d = STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            STOP: begin
                if (cyc_q == CYC_LAST) begin
                    cyc_d   = '0;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Line level for the coming cycle; the shift register LSB is always the bit on the wire.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        rd_en_d = (state_d == FETCH);
        busy_d  = (state_d != IDLE);
    end

    assign bus.tx         = tx_q;
    assign bus.fifo_rd_en = rd_en_q;
    assign bus.busy       = busy_q;
    assign bus.tx_done    = done_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO read-port model, frame-timeline reference model, directed frames.
module tb_fifo_uart_tx;

    localparam int unsigned CPB   = 4;
    localparam int          CPB_I = int'(CPB);
    localparam int          END_T = 3 + 10 * CPB_I;

    logic clk = 1'b0;
    logic rst = 1'b1;

    fifo_uart_tx_if intf ();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (intf.master)
    );

    always #5 clk = ~clk;

    int         n_chk    = 0;
    int         n_fail   = 0;
    int         rd_cnt   = 0;
    int         done_cnt = 0;
    int         cyc      = 0;
    bit         toggle_en = 1'b0;
    logic [7:0] q[$];

    // Reference timeline: t=0 idle, t=1 read pulse, t=2 load, t=3.. the 10 frame slots, END_T idle+done.
    int         m_t    = 0;
    logic [7:0] m_byte = 8'h00;

    function automatic logic model_tx(input int t, input logic [7:0] b);
        int k;
        if (t < 3 || t >= 3 + 10 * CPB_I) return 1'b1;
        k = (t - 3) / CPB_I;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0;
        end else if (m_t == 0 || m_t == END_T) begin
            if (!intf.fifo_empty) begin
                m_t    = 1;
                m_byte = (q.size() > 0) ? q[0] : 8'h00;
            end else begin
                m_t = 0;
            end
        end else begin
            m_t = m_t + 1;
        end
    end

    // Synchronous FIFO read side: data appears the cycle after a read pulse.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (intf.fifo_rd_en === 1'b1) begin
            rd_cnt = rd_cnt + 1;
            if (q.size() > 0) intf.fifo_data <= q.pop_front();
        end
        if (intf.tx_done === 1'b1) done_cnt = done_cnt + 1;
    end

    always @(negedge clk) begin
        if (toggle_en && intf.busy === 1'b1) intf.fifo_empty = ~intf.fifo_empty;
        else                                 intf.fifo_empty = (q.size() == 0);
    end

    // Cycle-by-cycle comparison against the timeline model.
    always @(negedge clk) begin
        logic [3:0] got, want;
        got  = {intf.tx, intf.fifo_rd_en, intf.busy, intf.tx_done};
        want = {model_tx(m_t, m_byte), (m_t == 1), (m_t >= 1 && m_t < END_T), (m_t == END_T)};
        n_chk = n_chk + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL cycle_cmp cyc=%0d t=%0d: tx,rd_en,busy,done got %b want %b", cyc, m_t, got, want);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_chk = n_chk + 1;
        if (got !== want) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic wait_fall(input string name, output int t_fall, output bit ok);
        ok     = 1'b0;
        t_fall = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (intf.tx === 1'b0) begin
                ok     = 1'b1;
                t_fall = cyc;
                break;
            end
        end
        if (!ok) check({name, "_start_timeout"}, 32'd0, 32'd1);
    endtask

    // exp[i] is the line level during slot i (0 = start bit, 9 = stop bit), sampled mid-bit.
    task automatic check_frame(input string name, input logic [9:0] exp, output int t_fall);
        bit ok;
        wait_fall(name, t_fall, ok);
        if (ok) begin
            repeat (CPB / 2) @(negedge clk);
            for (int i = 0; i < 10; i++) begin
                check($sformatf("%s_slot%0d", name, i), 32'(intf.tx), 32'(exp[i]));
                repeat (CPB) @(negedge clk);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  t0, t1, t2, tf;
        bit  ok;

        intf.fifo_empty = 1'b1;
        intf.fifo_data  = 8'h00;
        repeat (3) @(negedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);

        // Single byte 0xA5
        rd_cnt = 0; done_cnt = 0;
        q.push_back(8'hA5);
        check_frame("a5", 10'b1101001010, tf);
        check("a5_rd_pulses", 32'(rd_cnt), 32'd1);
        check("a5_done_pulses", 32'(done_cnt), 32'd1);
        check("a5_busy_after", 32'(intf.busy), 32'd0);

        // Three bytes back to back
        rd_cnt = 0; done_cnt = 0;
        q.push_back(8'h00); q.push_back(8'hFF); q.push_back(8'h55);
        check_frame("b00", 10'b1000000000, t0);
        check_frame("bff", 10'b1111111110, t1);
        check("gap_00_ff", 32'(t1 - t0), 32'd43);
        check_frame("b55", 10'b1010101010, t2);
        check("gap_ff_55", 32'(t2 - t1), 32'd43);
        repeat (4) @(negedge clk);
        check("b3_rd_pulses", 32'(rd_cnt), 32'd3);
        check("b3_done_pulses", 32'(done_cnt), 32'd3);

        // Empty FIFO for 200 cycles
        rd_cnt = 0;
        repeat (200) @(negedge clk);
        check("idle_rd_pulses", 32'(rd_cnt), 32'd0);
        check("idle_busy", 32'(intf.busy), 32'd0);
        check("idle_tx", 32'(intf.tx), 32'd1);

        // Reset in the middle of data bit 3 of 0x3C
        q.push_back(8'h3C);
        wait_fall("r3c", tf, ok);
        repeat (4 * CPB + 1) @(negedge clk);
        check("pre_rst_busy", 32'(intf.busy), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_tx", 32'(intf.tx), 32'd1);
        check("rst_rd_en", 32'(intf.fifo_rd_en), 32'd0);
        check("rst_busy", 32'(intf.busy), 32'd0);
        check("rst_done", 32'(intf.tx_done), 32'd0);
        @(negedge clk);
        @(negedge clk);
        #1 rst = 1'b0;
        rd_cnt = 0;
        q.push_back(8'h81);
        check_frame("r81", 10'b1100000010, tf);
        check("r81_rd_pulses", 32'(rd_cnt), 32'd1);

        // fifo_empty toggling while a frame is in flight
        rd_cnt = 0;
        toggle_en = 1'b1;
        q.push_back(8'h5A);
        check_frame("tg5a", 10'b1010110100, tf);
        toggle_en = 1'b0;
        repeat (4) @(negedge clk);
        check("tg_rd_pulses", 32'(rd_cnt), 32'd1);
        check("tg_busy_after", 32'(intf.busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
